// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the shared data memory.
// One instance per port; the arbiter sees the slave view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory,
// with a bounded lock for bursts and 1-cycle read return routing.
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wenable,
  output logic [DATA_W-1:0] mem_wvalue,
  input  logic [DATA_W-1:0] mem_rvalue
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_LOCK);

  logic          last_owner;
  logic          rd_pend;
  logic          rd_owner;
  logic          lock_q;
  logic [CW-1:0] lock_cnt;

  logic              any_req;
  logic              hold;
  logic              pick;
  logic              gnt;
  logic              sel_we;
  logic              sel_lock;
  logic              other_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // pick is the winning port index; gnt says whether anyone wins
  always_comb begin
    any_req = m0.req | m1.req;
    hold    = lock_q & (lock_cnt < CAP);
    pick    = m1.req;
    if (m0.req & m1.req)
      pick = hold ? last_owner : ~last_owner;
    gnt       = ~reset & any_req;
    sel_we    = pick ? m1.we    : m0.we;
    sel_lock  = pick ? m1.lock  : m0.lock;
    sel_addr  = pick ? m1.addr  : m0.addr;
    sel_wdata = pick ? m1.wdata : m0.wdata;
    other_req = pick ? m0.req   : m1.req;
  end

  assign m0.gnt = gnt & ~pick;
  assign m1.gnt = gnt & pick;

  assign mem_addr    = gnt ? sel_addr : '0;
  assign mem_wenable = gnt & sel_we;
  assign mem_wvalue  = (gnt & sel_we) ? sel_wdata : '0;

  assign m0.rvalid = ~reset & rd_pend & ~rd_owner;
  assign m1.rvalid = ~reset & rd_pend & rd_owner;
  assign m0.rdata  = mem_rvalue;
  assign m1.rdata  = mem_rvalue;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= 1'b1;
      lock_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      lock_q     <= 1'b0;
    end else if (gnt) begin
      last_owner <= pick;
      rd_pend    <= ~sel_we;
      rd_owner   <= pick;
      lock_q     <= sel_lock;
      // the run only grows while the other side is being held off
      if ((pick == last_owner) && other_req)
        lock_cnt <= (lock_cnt == CAP) ? CAP : lock_cnt + 1'b1;
      else
        lock_cnt <= CW'(1);
    end else begin
      rd_pend  <= 1'b0;
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against
// a rule-level model of arbitration and memory contents.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_wenable;
  logic [DW-1:0] mem_wvalue;
  logic [DW-1:0] mem_rvalue;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0),
    .m1          (m1),
    .mem_addr    (mem_addr),
    .mem_wenable (mem_wenable),
    .mem_wvalue  (mem_wvalue),
    .mem_rvalue  (mem_rvalue)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram [0:65535];

  always @(posedge clock) begin
    if (mem_wenable) ram[mem_addr] <= mem_wvalue;
    mem_rvalue <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [0:65535];
  int            m_last;
  int            m_run;
  bit            m_lock;
  bit            m_pend;
  int            m_pown;
  logic [DW-1:0] m_pdata;

  logic          d_g0, d_g1, d_we, d_rv0, d_rv1;
  logic [DW-1:0] d_rd0;
  logic [31:0]   gseq0 = '0;
  logic [31:0]   gseq1 = '0;
  bit            den0, den1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(bit r0, bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (m_lock && m_run < ML) return m_last;
    return 1 - m_last;
  endfunction

  task automatic cycle();
    int            g;
    bit            we;
    bit            lk;
    bit            oreq;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clock);
    g = reset ? -1 : model_grant(m0.req, m1.req);
    we   = (g == 1) ? m1.we    : m0.we;
    lk   = (g == 1) ? m1.lock  : m0.lock;
    a    = (g == 1) ? m1.addr  : m0.addr;
    wd   = (g == 1) ? m1.wdata : m0.wdata;
    oreq = (g == 1) ? m0.req   : m1.req;
    chk("gnt0", 32'(m0.gnt), 32'(g == 0));
    chk("gnt1", 32'(m1.gnt), 32'(g == 1));
    chk("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(a) : 32'd0);
    chk("mem_we", 32'(mem_wenable), 32'((g >= 0) && we));
    chk("mem_wv", 32'(mem_wvalue),
        ((g >= 0) && we) ? 32'(wd) : 32'd0);
    chk("rvalid0", 32'(m0.rvalid),
        32'(!reset && m_pend && m_pown == 0));
    chk("rvalid1", 32'(m1.rvalid),
        32'(!reset && m_pend && m_pown == 1));
    if (!reset && m_pend)
      chk("rdata", (m_pown == 0) ? 32'(m0.rdata) : 32'(m1.rdata),
          32'(m_pdata));
    d_g0 = m0.gnt; d_g1 = m1.gnt; d_we = mem_wenable;
    d_rv0 = m0.rvalid; d_rv1 = m1.rvalid; d_rd0 = m0.rdata;
    gseq0 = {gseq0[30:0], m0.gnt};
    gseq1 = {gseq1[30:0], m1.gnt};
    den0 = m0.req && g != 0;
    den1 = m1.req && g != 1;
    if (reset) begin
      m_last = 1; m_run = 0; m_lock = 0; m_pend = 0; m_pown = 0;
    end else if (g >= 0) begin
      m_pend  = !we;
      m_pown  = g;
      m_pdata = ref_mem[a];
      if (we) ref_mem[a] = wd;
      if (g == m_last && oreq) m_run = (m_run < ML) ? m_run + 1 : ML;
      else m_run = 1;
      m_lock = lk;
      m_last = g;
    end else begin
      m_pend = 0; m_run = 0; m_lock = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input bit w,
                          input bit l, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    if (p == 0) begin
      m0.req = r; m0.we = w; m0.lock = l; m0.addr = a; m0.wdata = d;
    end else begin
      m1.req = r; m1.we = w; m1.lock = l; m1.addr = a; m1.wdata = d;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    m_last = 1; m_run = 0; m_lock = 0; m_pend = 0; m_pown = 0;
    m_pdata = '0;

    // reset with both requesting
    reset = 1'b1;
    set_port(0, 1, 1, 0, 16'h0001, 16'hAAAA);
    set_port(1, 1, 1, 0, 16'h0002, 16'hBBBB);
    cycle();
    cycle();
    chk("rst_gnt0", 32'(d_g0), 32'd0);
    chk("rst_gnt1", 32'(d_g1), 32'd0);
    chk("rst_we", 32'(d_we), 32'd0);
    reset = 1'b0;
    set_port(0, 1, 0, 0, 16'h0001, 16'h0000);
    set_port(1, 1, 0, 0, 16'h0002, 16'h0000);
    cycle();
    chk("first_gnt0", 32'(d_g0), 32'd1);

    // m0 alone: write then read back
    set_port(1, 0, 0, 0, 16'h0000, 16'h0000);
    set_port(0, 1, 1, 0, 16'h0010, 16'h1234);
    cycle();
    chk("wr_gnt0", 32'(d_g0), 32'd1);
    chk("wr_we", 32'(d_we), 32'd1);
    set_port(0, 1, 0, 0, 16'h0010, 16'h0000);
    cycle();
    chk("rd_gnt0", 32'(d_g0), 32'd1);
    set_port(0, 0, 0, 0, 16'h0000, 16'h0000);
    cycle();
    chk("rd_rvalid0", 32'(d_rv0), 32'd1);
    chk("rd_rdata0", 32'(d_rd0), 32'h1234);
    chk("rd_rvalid1", 32'(d_rv1), 32'd0);

    // both reading without lock alternate
    set_port(0, 1, 0, 0, 16'h0010, 16'h0000);
    set_port(1, 1, 0, 0, 16'h0020, 16'h0000);
    repeat (4) cycle();
    chk("alternate", 32'(gseq0[3:0]), 32'(4'b0101));
    set_port(0, 0, 0, 0, 16'h0000, 16'h0000);
    set_port(1, 0, 0, 0, 16'h0000, 16'h0000);
    cycle();

    // make port 1 the last owner, then m0 locks under contention
    set_port(1, 1, 0, 0, 16'h0020, 16'h0000);
    cycle();
    set_port(1, 0, 0, 0, 16'h0000, 16'h0000);
    cycle();
    set_port(0, 1, 0, 1, 16'h0030, 16'h0000);
    set_port(1, 1, 0, 0, 16'h0040, 16'h0000);
    repeat (10) cycle();
    chk("lock_seq", 32'(gseq0[9:0]), 32'(10'b1111011110));
    set_port(0, 0, 0, 0, 16'h0000, 16'h0000);
    set_port(1, 0, 0, 0, 16'h0000, 16'h0000);
    cycle();

    // m1 streams uncontended, then m0 joins
    set_port(1, 1, 0, 1, 16'h0050, 16'h0000);
    repeat (8) cycle();
    chk("stream_m1", 32'(gseq1[7:0]), 32'hFF);
    set_port(0, 1, 0, 0, 16'h0060, 16'h0000);
    repeat (5) cycle();
    chk("cap_seq", 32'(gseq1[4:0]), 32'(5'b11101));
    set_port(0, 0, 0, 0, 16'h0000, 16'h0000);
    set_port(1, 0, 0, 0, 16'h0000, 16'h0000);
    cycle();

    // read, then reset swallows the return
    set_port(0, 1, 0, 0, 16'h0010, 16'h0000);
    cycle();
    chk("pre_rst_gnt0", 32'(d_g0), 32'd1);
    set_port(0, 0, 0, 0, 16'h0000, 16'h0000);
    reset = 1'b1;
    cycle();
    chk("rst_rvalid0", 32'(d_rv0), 32'd0);
    reset = 1'b0;
    set_port(0, 1, 0, 0, 16'h0011, 16'h0000);
    set_port(1, 1, 0, 0, 16'h0012, 16'h0000);
    cycle();
    chk("post_rst_gnt0", 32'(d_g0), 32'd1);

    // randomized traffic; denied requesters hold their request
    repeat (600) begin
      if (!den0)
        set_port(0, $urandom_range(0, 3) != 0, 1'($urandom),
                 1'($urandom), 16'($urandom_range(0, 15)),
                 16'($urandom));
      if (!den1)
        set_port(1, $urandom_range(0, 3) != 0, 1'($urandom),
                 1'($urandom), 16'($urandom_range(0, 15)),
                 16'($urandom));
      reset = ($urandom_range(0, 80) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
